// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM state encoding,
// instruction width and the default program-memory address width.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_NEXT    = 3'd5
  } fetch_state_e;

  // States in which an FCU redirect request is accepted into the latch.
  function automatic logic redirect_window(fetch_state_e s);
    return (s == S_ISSUE) || (s == S_WAIT_LO) || (s == S_WAIT_HI);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with reset value, sequential advance and a
// one-entry redirect latch.
//   clk, rst     : clock, async active-high reset
//   advance      : one-cycle pulse; apply latched redirect or increment
//   load         : capture load_target into the redirect latch
//   load_target  : redirect address
//   pc           : current program counter
//   pc_next      : value pc takes on the coming edge
module pc_reg #(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] target_d, target_q;
  logic              redir_d, redir_q;

  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    redir_d  = redir_q;
    // advance and load never coincide: the FSM only raises advance in NEXT,
    // where redirect requests are not accepted.
    if (advance) begin
      if (redir_q) begin
        pc_d    = target_q;
        redir_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end else if (load) begin
      redir_d  = 1'b1;
      target_d = load_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      target_q <= '0;
      redir_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      redir_q  <= redir_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   clk, rst              : clock, async active-high reset
//   en                    : run enable, gates the start of a new fetch
//   imem_rd/addr/data/valid : program-memory read handshake
//   ir, cs                : instruction register and one-cycle start strobe
//   ready1                : decoder completion (low then high ends an instr)
//   pc_load, pc_target    : FCU redirect request
//   pc                    : program counter
//   busy                  : high whenever the FSM is not idle
//   fetch_cnt             : instructions issued, wraps at 16 bits
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] ir,
  output logic               cs,
  input  logic               ready1,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic [15:0]        fetch_cnt
);

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic               cs_d, cs_q;
  logic               imem_rd_d, imem_rd_q;
  logic [ADDR_W-1:0]  imem_addr_d, imem_addr_q;
  logic [15:0]        fetch_cnt_d, fetch_cnt_q;
  logic [ADDR_W-1:0]  pc_next;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .advance     (state_q == S_NEXT),
    .load        (pc_load && redirect_window(state_q)),
    .load_target (pc_target),
    .pc          (pc),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cs_d        = 1'b0;
    imem_rd_d   = imem_rd_q;
    imem_addr_d = imem_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d     = S_FETCH;
          imem_rd_d   = 1'b1;
          imem_addr_d = pc;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          state_d     = S_ISSUE;
          ir_d        = imem_data;
          imem_rd_d   = 1'b0;
          cs_d        = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
      end
      S_ISSUE:   state_d = S_WAIT_LO;
      S_WAIT_LO: if (ready1 == 1'b0) state_d = S_WAIT_HI;
      S_WAIT_HI: if (ready1 == 1'b1) state_d = S_NEXT;
      S_NEXT: begin
        // The PC updates on this same edge, so the next fetch address is
        // taken from pc_reg's next-value output rather than pc.
        if (en) begin
          state_d     = S_FETCH;
          imem_rd_d   = 1'b1;
          imem_addr_d = pc_next;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      cs_q        <= 1'b0;
      imem_rd_q   <= 1'b0;
      imem_addr_q <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cs_q        <= cs_d;
      imem_rd_q   <= imem_rd_d;
      imem_addr_q <= imem_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign ir        = ir_q;
  assign cs        = cs_q;
  assign imem_rd   = imem_rd_q;
  assign imem_addr = imem_addr_q;
  assign fetch_cnt = fetch_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // DUT 1: default reset PC
  logic        en, imem_valid, ready1, pc_load;
  logic [31:0] imem_data;
  logic [15:0] pc_target;
  logic        imem_rd, cs, busy;
  logic [15:0] imem_addr, pc, fetch_cnt;
  logic [31:0] ir;

  // DUT 2: reset PC at the top of the address space
  logic        en2, imem_valid2, ready2;
  logic [31:0] imem_data2;
  logic        imem_rd2, cs2, busy2;
  logic [15:0] imem_addr2, pc2, fetch_cnt2;
  logic [31:0] ir2;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_valid(imem_valid), .ir(ir), .cs(cs), .ready1(ready1),
    .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .busy(busy),
    .fetch_cnt(fetch_cnt)
  );

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk(clk), .rst(rst), .en(en2),
    .imem_rd(imem_rd2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .imem_valid(imem_valid2), .ir(ir2), .cs(cs2), .ready1(ready2),
    .pc_load(1'b0), .pc_target(16'h0000), .pc(pc2), .busy(busy2),
    .fetch_cnt(fetch_cnt2)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic        r1;
    logic        ld;
    logic [15:0] tgt;
    logic        rd;
    logic [15:0] addr;
    logic        cs;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t v(logic en_i, logic val_i, logic [31:0] data_i, logic r1_i,
                             logic ld_i, logic [15:0] tgt_i, logic rd_e, logic [15:0] addr_e,
                             logic cs_e, logic [31:0] ir_e, logic [15:0] pc_e, logic busy_e,
                             logic [15:0] cnt_e);
    vec_t r;
    r.en = en_i; r.valid = val_i; r.data = data_i; r.r1 = r1_i; r.ld = ld_i; r.tgt = tgt_i;
    r.rd = rd_e; r.addr = addr_e; r.cs = cs_e; r.ir = ir_e; r.pc = pc_e; r.busy = busy_e;
    r.cnt = cnt_e;
    return r;
  endfunction

  task automatic check_reset1(input string tag);
    check({tag, ".rd"},   32'(imem_rd),   32'h0);
    check({tag, ".addr"}, 32'(imem_addr), 32'h0);
    check({tag, ".cs"},   32'(cs),        32'h0);
    check({tag, ".ir"},   ir,             32'h0);
    check({tag, ".pc"},   32'(pc),        32'h0);
    check({tag, ".busy"}, 32'(busy),      32'h0);
    check({tag, ".cnt"},  32'(fetch_cnt), 32'h0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    // Inputs applied before an edge; outputs expected just after it.
    //           en val data          r1 ld tgt        | rd addr      cs ir            pc       busy cnt
    // Instruction 0: two memory wait states, decoder low 3 cycles
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0000, O, 32'h0,        16'h0000, I, 16'd0)); // FETCH
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0000, O, 32'h0,        16'h0000, I, 16'd0));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0000, O, 32'h0,        16'h0000, I, 16'd0));
    vecs.push_back(v(I, I, 32'h0020_0005, I, O, 16'h0000, O, 16'h0000, I, 32'h0020_0005, 16'h0000, I, 16'd1)); // ISSUE
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, O, 16'h0000, O, 32'h0020_0005, 16'h0000, I, 16'd1)); // WAIT_LO
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0000, O, 32'h0020_0005, 16'h0000, I, 16'd1)); // WAIT_HI
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0000, O, 32'h0020_0005, 16'h0000, I, 16'd1));
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0000, O, 32'h0020_0005, 16'h0000, I, 16'd1));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, O, 16'h0000, O, 32'h0020_0005, 16'h0000, I, 16'd1)); // NEXT
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0001, O, 32'h0020_0005, 16'h0001, I, 16'd1)); // FETCH @1
    // Instruction 1: redirect to 0x0040 during WAIT_LO
    vecs.push_back(v(I, I, 32'hDEAD_BEEF, I, O, 16'h0000, O, 16'h0001, I, 32'hDEAD_BEEF, 16'h0001, I, 16'd2));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, O, 16'h0001, O, 32'hDEAD_BEEF, 16'h0001, I, 16'd2));
    vecs.push_back(v(I, O, 32'h0,         I, I, 16'h0040, O, 16'h0001, O, 32'hDEAD_BEEF, 16'h0001, I, 16'd2));
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0001, O, 32'hDEAD_BEEF, 16'h0001, I, 16'd2));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, O, 16'h0001, O, 32'hDEAD_BEEF, 16'h0001, I, 16'd2));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0040, O, 32'hDEAD_BEEF, 16'h0040, I, 16'd2));
    // Instruction 2: load in FETCH ignored, 0x0010 then 0x0020 (last on WAIT_HI exit) wins
    vecs.push_back(v(I, O, 32'h0,         I, I, 16'h7777, I, 16'h0040, O, 32'hDEAD_BEEF, 16'h0040, I, 16'd2));
    vecs.push_back(v(I, I, 32'h1234_5678, I, O, 16'h0000, O, 16'h0040, I, 32'h1234_5678, 16'h0040, I, 16'd3));
    vecs.push_back(v(I, O, 32'h0,         I, I, 16'h0010, O, 16'h0040, O, 32'h1234_5678, 16'h0040, I, 16'd3));
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0040, O, 32'h1234_5678, 16'h0040, I, 16'd3));
    vecs.push_back(v(I, O, 32'h0,         I, I, 16'h0020, O, 16'h0040, O, 32'h1234_5678, 16'h0040, I, 16'd3));
    vecs.push_back(v(I, O, 32'h0,         I, I, 16'h0999, I, 16'h0020, O, 32'h1234_5678, 16'h0020, I, 16'd3));
    // Instruction 3: en dropped in WAIT_HI, completes then parks in IDLE
    vecs.push_back(v(I, I, 32'hA5A5_0001, I, O, 16'h0000, O, 16'h0020, I, 32'hA5A5_0001, 16'h0020, I, 16'd4));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0020, I, 16'd4));
    vecs.push_back(v(I, O, 32'h0,         O, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0020, I, 16'd4));
    vecs.push_back(v(O, O, 32'h0,         O, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0020, I, 16'd4));
    vecs.push_back(v(O, O, 32'h0,         I, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0020, I, 16'd4));
    vecs.push_back(v(O, O, 32'h0,         I, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0021, O, 16'd4)); // IDLE
    vecs.push_back(v(O, I, 32'hFFFF_FFFF, I, O, 16'h0000, O, 16'h0020, O, 32'hA5A5_0001, 16'h0021, O, 16'd4));
    vecs.push_back(v(I, O, 32'h0,         I, O, 16'h0000, I, 16'h0021, O, 32'hA5A5_0001, 16'h0021, I, 16'd4)); // FETCH @21

    rst = 1'b1;
    en = 1'b0; imem_valid = 1'b0; imem_data = '0; ready1 = 1'b1; pc_load = 1'b0; pc_target = '0;
    en2 = 1'b0; imem_valid2 = 1'b0; imem_data2 = '0; ready2 = 1'b1;
    #12;
    check_reset1("reset");
    check("reset2.pc",   32'(pc2),        32'h0000_FFFF);
    check("reset2.addr", 32'(imem_addr2), 32'h0000_FFFF);
    check("reset2.busy", 32'(busy2),      32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].en; imem_valid = vecs[i].valid; imem_data = vecs[i].data;
      ready1 = vecs[i].r1; pc_load = vecs[i].ld; pc_target = vecs[i].tgt;
      tick();
      check($sformatf("v%0d.rd", i),   32'(imem_rd),   32'(vecs[i].rd));
      check($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d.cs", i),   32'(cs),        32'(vecs[i].cs));
      check($sformatf("v%0d.ir", i),   ir,             vecs[i].ir);
      check($sformatf("v%0d.pc", i),   32'(pc),        32'(vecs[i].pc));
      check($sformatf("v%0d.busy", i), 32'(busy),      32'(vecs[i].busy));
      check($sformatf("v%0d.cnt", i),  32'(fetch_cnt), 32'(vecs[i].cnt));
    end

    // Asynchronous reset while a fetch is outstanding (imem_rd high)
    pc_load = 1'b0;
    rst = 1'b1;
    #1;
    check_reset1("async_rst");
    #1;
    en = 1'b0;
    rst = 1'b0;
    tick();
    imem_valid = 1'b1; imem_data = 32'hCAFE_F00D;
    tick();
    imem_valid = 1'b0;
    tick();
    check("post_rst.ir",   ir,             32'h0);
    check("post_rst.busy", 32'(busy),      32'h0);
    check("post_rst.rd",   32'(imem_rd),   32'h0);
    check("post_rst.cs",   32'(cs),        32'h0);
    check("post_rst.cnt",  32'(fetch_cnt), 32'h0);

    // PC wrap from 0xFFFF, zero-wait memory and decoder
    en2 = 1'b1;
    tick();                                            // FETCH
    check("wrap.fetch_rd",   32'(imem_rd2),   32'h1);
    check("wrap.fetch_addr", 32'(imem_addr2), 32'h0000_FFFF);
    imem_valid2 = 1'b1; imem_data2 = 32'h0000_0001;
    tick();                                            // ISSUE
    imem_valid2 = 1'b0;
    check("wrap.cs",  32'(cs2), 32'h1);
    check("wrap.ir",  ir2,      32'h0000_0001);
    tick();                                            // WAIT_LO
    check("wrap.cs_once", 32'(cs2), 32'h0);
    ready2 = 1'b0;
    tick();                                            // WAIT_HI
    ready2 = 1'b1;
    tick();                                            // NEXT
    en2 = 1'b0;
    tick();                                            // IDLE
    check("wrap.pc",   32'(pc2),        32'h0);
    check("wrap.busy", 32'(busy2),      32'h0);
    check("wrap.cnt",  32'(fetch_cnt2), 32'h1);
    check("wrap.rd",   32'(imem_rd2),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Holds the program counter and reads 32-bit instructions from program memory through a valid handshake.
- Presents each instruction on ir with a one-cycle cs strobe, then waits for the decoder's ready1 low→high completion before advancing.
- Applies PC redirects from the flow-control unit (FCU).

Parameters:
- ADDR_W, 16, program-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; when low, no new fetch starts.
- imem_rd  output  1  read request to program memory.
- imem_addr  output  ADDR_W  word address for the read.
- imem_data  input  32  instruction word from memory.
- imem_valid  input  1  imem_data valid this cycle.
- ir  output  32  instruction register to the decoder.
- cs  output  1  decoder start strobe.
- ready1  input  1  decoder completion/ready.
- pc_load  input  1  FCU redirect request.
- pc_target  input  ADDR_W  FCU redirect address.
- pc  output  ADDR_W  address of the instruction currently in ir.
- busy  output  1  high in every state except IDLE.
- fetch_cnt  output  16  count of instructions issued to the decoder.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - pc=RESET_PC, ir=32'h0, cs=0, imem_rd=0, imem_addr=RESET_PC, busy=0, fetch_cnt=0.
  - State=IDLE; redirect latch cleared.
- IDLE:
  - If en=1, go to FETCH next cycle with imem_addr=pc and imem_rd=1.
- FETCH:
  - imem_rd held at 1 and imem_addr held stable until imem_valid=1.
  - On imem_valid: ir<=imem_data, imem_rd<=0, go to ISSUE.
  - imem_valid while not in FETCH is ignored.
- ISSUE:
  - cs=1 for exactly one cycle; ir stable from then until the next FETCH completes.
  - fetch_cnt increments by 1 and wraps at 16'hFFFF→0.
  - Next state WAIT_LO.
- WAIT_LO:
  - Wait for ready1==1'b0, meaning the decoder accepted the instruction.
  - A ready1 of 1 or Z/X is not treated as low.
- WAIT_HI:
  - Wait for ready1==1'b1; then go to NEXT.
- NEXT (one cycle):
  - If the redirect latch is set, pc<=pc_target_latched and clear the latch.
  - Otherwise pc<=pc+1, wrapping modulo 2^ADDR_W.
  - Then go to FETCH if en=1, else IDLE.
- Redirect latch:
  - pc_load=1 in ISSUE, WAIT_LO or WAIT_HI sets the latch and captures pc_target.
  - A later pc_load before NEXT overwrites the target (last wins).
  - pc_load in IDLE/FETCH/NEXT is ignored.
  - pc_load in the same cycle ready1 rises (WAIT_HI exit) is captured and used in the following NEXT.
- en deasserted mid-instruction: the current instruction completes through NEXT, then the block parks in IDLE. It never aborts a decoder handshake.
- Minimum instruction latency with zero-wait memory and decoder: IDLE→FETCH→ISSUE→WAIT_LO→WAIT_HI→NEXT is 5 cycles from FETCH entry to the next FETCH, plus decoder time.
- cs is a registered output with no combinational path from any input; imem_rd and imem_addr are registered.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state encoding: IDLE=0, FETCH=1, ISSUE=2, WAIT_LO=3, WAIT_HI=4, NEXT=5, on a 3-bit state type.
  - INSTR_W=32.
  - Default ADDR_W.
- Natural sub-module: pc_reg, holding the PC with increment/load/reset and the redirect latch.
- The FSM and ir register stay in fetch_unit.

Test Plan:
- Reset, en=1, memory returns 32'h0020_0005 at addr 0 with 2 wait cycles, decoder model drops ready1 1 cycle after cs and raises it 3 cycles later → ir=32'h0020_0005, one cs pulse, then pc=1, imem_addr=1, fetch_cnt=1.
- pc_load=1, pc_target=16'h0040 during WAIT_LO → next fetch at imem_addr=16'h0040, pc=16'h0040.
- Two pc_load pulses, targets 16'h0010 then 16'h0020, in one instruction → next fetch at 16'h0020.
- RESET_PC=16'hFFFF, no redirect → after the first instruction, pc wraps to 16'h0000.
- en dropped during WAIT_HI → instruction completes, pc increments, state IDLE, busy=0, no imem_rd.
- rst asserted during FETCH with imem_rd=1 → same-cycle imem_rd=0, cs=0, pc=RESET_PC, fetch_cnt=0; a later imem_valid pulse is ignored.
